// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the seq_divider restoring divider.
// The signed variant is enabled with the SEQ_DIVIDER_SIGNED_EN macro.
package seq_divider_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [MAX_W:0] rem;
    logic           qbit;
  } step_res_t;

  // Quotient reported for a zero divisor: the low w bits set, the rest clear.
  function automatic logic [MAX_W-1:0] div_zero_quot(input int w);
    logic [MAX_W-1:0] v;
    v = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) v[i] = 1'b1;
      else       v[i] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor through a subtract-mode ripple chain, then select.
module div_restore_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  localparam logic SUB_MODE = 1'b1;

  logic [WIDTH:0]   a_s;
  logic [WIDTH:0]   b_s;
  logic [WIDTH+1:0] c_s;
  logic [WIDTH-1:0] diff_s;

  assign a_s    = {r_in, q_msb};
  assign b_s    = {1'b0, divisor} ^ {(WIDTH+1){SUB_MODE}};
  assign c_s[0] = SUB_MODE;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_carry
    assign c_s[i+1] = (a_s[i] & b_s[i]) | (c_s[i] & (a_s[i] ^ b_s[i]));
  end

  // The kept remainder is always below the divisor, so its top bit is never needed.
  for (genvar i = 0; i < WIDTH; i++) begin : g_diff
    assign diff_s[i] = a_s[i] ^ b_s[i] ^ c_s[i];
  end

  assign q_bit = c_s[WIDTH+1];
  assign r_out = q_bit ? diff_s : a_s[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider behind a start/done handshake, one step per clock.
// Optional two's-complement operands with SEQ_DIVIDER_SIGNED_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [MAX_W-1:0] DZ_ALL = div_zero_quot(WIDTH);
  localparam logic [WIDTH-1:0] DZ_QUOT = DZ_ALL[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shq_q, shq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_r_s;
  logic             step_q_s;
  logic [WIDTH-1:0] raw_q_s;
  logic [WIDTH-1:0] fix_q_s;
  logic [WIDTH-1:0] fix_r_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .r_in   (rem_q),
    .q_msb  (shq_q[WIDTH-1]),
    .divisor(dvs_q),
    .r_out  (step_r_s),
    .q_bit  (step_q_s)
  );

  assign raw_q_s = {shq_q[WIDTH-2:0], step_q_s};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  // The core divides magnitudes; signs are reapplied on the final step.
  assign dvd_mag_s = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign dvs_mag_s = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
  assign fix_q_s   = qneg_q ? (~raw_q_s  + WIDTH'(1)) : raw_q_s;
  assign fix_r_s   = rneg_q ? (~step_r_s + WIDTH'(1)) : step_r_s;

  // Sign flags captured at accept.
  always_comb begin
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if ((state_q != RUN) && start) begin
      qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_d = dividend[WIDTH-1];
    end else begin
      qneg_d = qneg_q;
      rneg_d = rneg_q;
    end
  end

  // Sign flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign dvd_mag_s = dividend;
  assign dvs_mag_s = divisor;
  assign fix_q_s   = raw_q_s;
  assign fix_r_s   = step_r_s;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    shq_d   = shq_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rem_d = {WIDTH{1'b0}};
          shq_d = dvd_mag_s;
          dvs_d = dvs_mag_s;
          cnt_d = CNT_W'(WIDTH);
          dbz_d = 1'b0;
          if (divisor == {WIDTH{1'b0}}) begin
            state_d = DONE;
            quot_d  = DZ_QUOT;
            remo_d  = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = step_r_s;
        shq_d = raw_q_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          quot_d  = fix_q_s;
          remo_d  = fix_r_s;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= {WIDTH{1'b0}};
      shq_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      quot_q  <= {WIDTH{1'b0}};
      remo_q  <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shq_q   <= shq_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule
